// File: rtl/caravel_ips_pkg.sv
// rtl/caravel_ips_pkg.sv - shared FSM encoding and status codes for the Wishbone command master
package caravel_ips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wbm_state_e;

  localparam logic [1:0] WBM_OK      = 2'b00;
  localparam logic [1:0] WBM_BUSERR  = 2'b01;
  localparam logic [1:0] WBM_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_cmd_master_if.sv
// rtl/wb_cmd_master_if.sv - command/response port and Wishbone initiator bus bundle
interface wb_cmd_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic [SW-1:0] cmd_sel_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_dat_o;
  logic [1:0]    rsp_status_o;

  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [SW-1:0] wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [DW-1:0] wbm_dat_i;
  logic          wbm_ack_i;
  logic          wbm_err_i;

  // master: the initiator itself; slave: the agent issuing commands plus the peripheral
  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  rsp_ready_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    output rsp_ready_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );

endinterface

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic initiator: one bus access per command, with timeout
module wb_cmd_master
  import caravel_ips_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  wb_cmd_master_if.master  bus
);

  localparam int SW = DW / 8;
  localparam int TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  wbm_state_e    state;
  logic [TW-1:0] timer;
  logic          cyc_q;
  logic          stb_q;
  logic          we_q;
  logic [SW-1:0] sel_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dat_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_dat_q;
  logic [1:0]    rsp_status_q;
  logic          timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TLAST);

  // Ready is gated by reset so nothing is accepted while the block is held in reset
  assign bus.cmd_ready_o  = (state == ST_IDLE) && !wb_rst_i;
  assign bus.wbm_cyc_o    = cyc_q;
  assign bus.wbm_stb_o    = stb_q;
  assign bus.wbm_we_o     = we_q;
  assign bus.wbm_sel_o    = sel_q;
  assign bus.wbm_adr_o    = adr_q;
  assign bus.wbm_dat_o    = dat_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_status_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= ST_IDLE;
      timer        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= WBM_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid_i) begin
            we_q  <= bus.cmd_we_i;
            adr_q <= bus.cmd_adr_i;
            dat_q <= bus.cmd_dat_i;
            sel_q <= bus.cmd_sel_i;
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            timer <= '0;
            state <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (bus.wbm_err_i || bus.wbm_ack_i || timeout_hit) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= {AW{1'b0}};
            dat_q       <= {DW{1'b0}};
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
            // err beats ack, and a real slave answer beats a coincident timeout
            if (bus.wbm_err_i) begin
              rsp_status_q <= WBM_BUSERR;
              rsp_dat_q    <= '0;
            end else if (bus.wbm_ack_i) begin
              rsp_status_q <= WBM_OK;
              rsp_dat_q    <= we_q ? '0 : bus.wbm_dat_i;
            end else begin
              rsp_status_q <= WBM_TIMEOUT;
              rsp_dat_q    <= '0;
            end
          end else if (timer != {TW{1'b1}}) begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= WBM_OK;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
